// File: rtl/timer_display_scan.sv
// Three-digit multiplexed common-anode seven-segment scanner for the countdown timer.
// Digits are captured once per frame; leading-zero blanking, error glyph and stop blink.
module timer_display_scan #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned GUARD        = 500,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] First,
    input  logic [3:0] Second,
    input  logic [3:0] Third,
    input  logic       Stop,
    output logic [2:0] An,
    output logic [6:0] Seg
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        SLOT_ONES     = 2'd0,
        SLOT_TENS     = 2'd1,
        SLOT_HUNDREDS = 2'd2
    } slot_t;

    slot_t          slot, slot_nxt;
    logic [CW-1:0]  refresh_cnt, refresh_cnt_nxt;
    logic [BW-1:0]  blink_cnt, blink_cnt_nxt;
    logic           blink_on, blink_on_nxt;
    logic [3:0]     sh_first, sh_second, sh_third;
    logic           sh_stop;
    logic           slot_end, frame_end;
    logic [3:0]     digit;
    logic           blank;
    logic [6:0]     glyph;
    logic [2:0]     an_nxt;
    logic [6:0]     seg_nxt;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            refresh_cnt <= '0;
            slot        <= SLOT_ONES;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            sh_first    <= '0;
            sh_second   <= '0;
            sh_third    <= '0;
            sh_stop     <= 1'b0;
            An          <= '1;
            Seg         <= '1;
        end else begin
            refresh_cnt <= refresh_cnt_nxt;
            slot        <= slot_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_on    <= blink_on_nxt;
            An          <= an_nxt;
            Seg         <= seg_nxt;
            if (frame_end) begin
                sh_first  <= First;
                sh_second <= Second;
                sh_third  <= Third;
                sh_stop   <= Stop;
            end
        end
    end

    always_comb begin
        slot_end        = (refresh_cnt == CW'(REFRESH_DIV - 1));
        frame_end       = slot_end && (slot == SLOT_HUNDREDS);
        refresh_cnt_nxt = slot_end ? '0 : refresh_cnt + 1'b1;
        slot_nxt        = slot;
        blink_cnt_nxt   = blink_cnt;
        blink_on_nxt    = blink_on;
        if (slot_end) begin
            case (slot)
                SLOT_ONES: slot_nxt = SLOT_TENS;
                SLOT_TENS: slot_nxt = SLOT_HUNDREDS;
                default:   slot_nxt = SLOT_ONES;
            endcase
        end
        // Counting only runs once Stop was already captured, so the first stopped phase is a full ON phase
        if (frame_end) begin
            if (!Stop || !sh_stop) begin
                blink_cnt_nxt = '0;
                blink_on_nxt  = 1'b1;
            end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_nxt = '0;
                blink_on_nxt  = ~blink_on;
            end else begin
                blink_cnt_nxt = blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        digit = sh_first;
        blank = 1'b0;
        case (slot)
            SLOT_TENS: begin
                digit = sh_second;
                blank = (sh_third == 4'd0) && (sh_second == 4'd0);
            end
            SLOT_HUNDREDS: begin
                digit = sh_third;
                blank = (sh_third == 4'd0);
            end
            default: begin
                digit = sh_first;
                blank = 1'b0;
            end
        endcase

        case (digit)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h79;
        endcase

        an_nxt  = '1;
        seg_nxt = '1;
        if ((refresh_cnt >= CW'(GUARD)) && blink_on && !blank) begin
            case (slot)
                SLOT_TENS:     an_nxt = 3'b101;
                SLOT_HUNDREDS: an_nxt = 3'b011;
                default:       an_nxt = 3'b110;
            endcase
            seg_nxt = ~glyph;
        end
    end

endmodule

// File: doc/timer_display_scan.md
Name: timer_display_scan

Overview:
- Downstream consumer of the game countdown timer: takes its three BCD digits (hundreds/tens/ones) plus its Stop flag and drives a 3-digit multiplexed common-anode seven-segment display.
- Time-multiplexes the digits with a refresh prescaler and a ghosting guard interval.
- Captures the digits once per scan frame so the display never tears.
- Applies leading-zero blanking, shows an error glyph for non-BCD input, and blinks the whole display while Stop is asserted.

Parameters:
- REFRESH_DIV, 50000, clock cycles per digit slot (min 2).
- GUARD, 500, cycles at the start of each slot with all anodes off (must be < REFRESH_DIV).
- BLINK_FRAMES, 64, scan frames per blink half-period while stopped (min 1).

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  reset, synchronous, active-low.
- First  input  4  ones digit, BCD.
- Second  input  4  tens digit, BCD.
- Third  input  4  hundreds digit, BCD.
- Stop  input  1  timer expired; 1 = blink display.
- An  output  3  anode enables, active-low; An[0]=ones, An[1]=tens, An[2]=hundreds.
- Seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (Rst=0 at a rising edge):
  - refresh_cnt=0, slot=0, blink_cnt=0, blink_on=1.
  - Shadow digits and shadow stop = 0.
  - An=3'b111, Seg=7'b1111111.
  - Reset mid-frame aborts the scan immediately; the first frame after release starts at slot 0.
- Refresh counter: counts 0..REFRESH_DIV-1, then wraps to 0 and advances slot 0→1→2→0. Slot 0 = ones, 1 = tens, 2 = hundreds.
- Frame capture:
  - On the cycle refresh_cnt wraps with slot=2 (frame end), latch First/Second/Third/Stop into the shadow registers.
  - The new values are used from slot 0 of the next frame.
  - Input changes at any other time have no effect until the next frame end.
- Blink:
  - Frame end with captured stop=0: blink_cnt=0, blink_on=1.
  - Frame end with captured stop=1: if blink_cnt==BLINK_FRAMES-1, toggle blink_on and clear blink_cnt; else increment blink_cnt.
  - The first blink phase after Stop rises is ON. A Stop deassertion restores steady display at the next frame boundary.
- Blanking (computed from shadow digits):
  - hundreds blank if shadow Third==0.
  - tens blank if hundreds blank and shadow Second==0.
  - ones never blanked ("000" displays as "  0").
- Decode (active-high {g..a} patterns, inverted on output):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
  - Any value 10..15 shows E (79); error overrides blanking.
  - Examples on Seg: 0 → 7'b1000000, 1 → 7'b1111001, 8 → 7'b0000000, E → 7'b0000110.
- Outputs, registered; pins reflect the internal state of the previous cycle (1-cycle latency):
  - An[slot]=0, others 1, only when refresh_cnt ≥ GUARD, blink_on=1, and the current digit is not blanked; otherwise An=3'b111.
  - Seg = decoded current-slot digit when its anode is on, else 7'b1111111.
- Never more than one anode low in any cycle.

Test Plan:
- Bench parameters for all scenarios: REFRESH_DIV=4, GUARD=1, BLINK_FRAMES=2.
- Reset: hold Rst=0 for 3 cycles with digits 1,0,0 → An=111, Seg=1111111. Release → first frame shows old shadow 000, i.e. only ones slot lit with Seg=1000000, and An=110 for 3 of 4 cycles. From the second frame, "100" shows: An cycles 110,101,011 with Seg 1000000,1000000,1111001, each preceded by 1 guard cycle of An=111.
- Leading zeros: digits 0,0,7 captured → only An=110 ever active, Seg=1111000. Digits 0,5,0 captured → An[1] and An[0] active, An[2] never low.
- Tearing: change Second from 9 to 8 mid-slot-1 → the tens shows 9 (Seg=0010000) until the next frame, then 8 (Seg=0000000).
- Blink: Stop=1 with digits 000 captured → 2 frames with An[0] lit, 2 frames An=111, repeating. Drop Stop → steady ones digit from the next frame.
- Invalid BCD: First=4'hC → ones slot Seg=0000110. Third=4'hF with Second=0 → hundreds shows E and tens shows 0 (not blanked).
- Reset mid-operation: assert Rst=0 during slot 2 of a blink-off phase, then release → outputs reset next cycle, and the scan restarts at slot 0 with blink_on=1.
